// File: rtl/parking_io_pkg.sv
// Shared types and constants for the parking controller's board-side I/O blocks.
package parking_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } act_state_t;

  localparam int unsigned DROP_COUNT_W = 8;

  // Width able to hold max(a,b)-1, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/actuator_pulse_driver_if.sv
// Event/actuator signal bundle for actuator_pulse_driver.
// ACT_DROP_COUNT_EN adds the 8-bit drop_count signal.
interface actuator_pulse_driver_if #(
  parameter int unsigned QUEUE_DEPTH = 3
);
  import parking_io_pkg::*;

  localparam int unsigned PW = $clog2(QUEUE_DEPTH + 1);

  logic          event_pulse;
  logic          drive_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          dropped;
`ifdef ACT_DROP_COUNT_EN
  logic [DROP_COUNT_W-1:0] drop_count;

  modport master (output event_pulse, input drive_out, busy, pending, dropped, drop_count);
  modport slave  (input event_pulse, output drive_out, busy, pending, dropped, drop_count);
`else
  modport master (output event_pulse, input drive_out, busy, pending, dropped);
  modport slave  (input event_pulse, output drive_out, busy, pending, dropped);
`endif

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module cycle_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/actuator_pulse_driver.sv
// Turns single-cycle events into actuator pulses with guaranteed high time and low gap.
// Optional ACT_DROP_COUNT_EN adds a saturating drop_count output.
module actuator_pulse_driver
  import parking_io_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned QUEUE_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  actuator_pulse_driver_if.slave bus
);

  localparam int unsigned   TW         = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned   PW         = $clog2(QUEUE_DEPTH + 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] QUEUE_FULL = PW'(QUEUE_DEPTH);

  act_state_t    state;
  logic          drive_q;
  logic          busy_q;
  logic          dropped_q;
  logic [PW-1:0] pending_q;
`ifdef ACT_DROP_COUNT_EN
  logic [DROP_COUNT_W-1:0] drop_count_q;
`endif

  logic          t_zero;
  logic          t_load;
  logic [TW-1:0] t_value;
  logic          start;
  logic          hold_end;
  logic          gap_exit;
  logic          queue_evt;

  // An event on the GAP-exit edge is consumed by the exit decision, never queued.
  always_comb begin
    start     = (state == IDLE) && bus.event_pulse;
    hold_end  = (state == HOLD) && t_zero;
    gap_exit  = (state == GAP) && t_zero;
    queue_evt = bus.event_pulse && ((state == HOLD) || ((state == GAP) && !t_zero));
    t_load    = start || hold_end || (gap_exit && ((pending_q != '0) || bus.event_pulse));
    t_value   = hold_end ? GAP_LOAD : HOLD_LOAD;
  end

  cycle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (t_load),
    .load_value(t_value),
    .zero      (t_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      dropped_q <= 1'b0;
`ifdef ACT_DROP_COUNT_EN
      drop_count_q <= '0;
`endif
    end else begin
      dropped_q <= 1'b0;
      if (queue_evt) begin
        if (pending_q != QUEUE_FULL) begin
          pending_q <= pending_q + PW'(1);
        end else begin
          dropped_q <= 1'b1;
`ifdef ACT_DROP_COUNT_EN
          if (drop_count_q != '1) drop_count_q <= drop_count_q + DROP_COUNT_W'(1);
`endif
        end
      end
      case (state)
        IDLE: begin
          if (bus.event_pulse) begin
            state   <= HOLD;
            drive_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (t_zero) begin
            state   <= GAP;
            drive_q <= 1'b0;
          end
        end
        GAP: begin
          if (t_zero) begin
            if ((pending_q != '0) || bus.event_pulse) begin
              state   <= HOLD;
              drive_q <= 1'b1;
              // A simultaneous event replaces the dequeued one: pending is unchanged.
              if ((pending_q != '0) && !bus.event_pulse) pending_q <= pending_q - PW'(1);
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.drive_out = drive_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;
  assign bus.dropped   = dropped_q;
`ifdef ACT_DROP_COUNT_EN
  assign bus.drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_actuator_pulse_driver.sv
// Directed self-checking bench for actuator_pulse_driver (HOLD=8, GAP=4, QUEUE=3).
module tb_actuator_pulse_driver;
  import parking_io_pkg::*;

  localparam int unsigned T_HOLD  = 8;
  localparam int unsigned T_GAP   = 4;
  localparam int unsigned T_QUEUE = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  actuator_pulse_driver_if #(.QUEUE_DEPTH(T_QUEUE)) bus ();

  actuator_pulse_driver #(
    .HOLD_CYCLES(T_HOLD),
    .GAP_CYCLES (T_GAP),
    .QUEUE_DEPTH(T_QUEUE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // Present ev for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic ev);
    bus.event_pulse = ev;
    @(posedge clk);
    #1;
    bus.event_pulse = 1'b0;
  endtask

  initial begin
    int rises;
    logic prev;
    int exp_p;

    reset = 1'b1;
    bus.event_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_drive", 0, bus.drive_out, 0);
    check("rst_busy", 0, bus.busy, 0);
    check("rst_pending", 0, bus.pending, 0);
    check("rst_dropped", 0, bus.dropped, 0);
    reset = 1'b0;
    step(1'b0);
    step(1'b0);

    // Single event: high 8 edges, busy 12 edges.
    for (int i = 0; i <= 14; i++) begin
      step(i == 0);
      check("s1_drive", i, bus.drive_out, (i < 8));
      check("s1_busy", i, bus.busy, (i < 12));
      check("s1_pending", i, bus.pending, 0);
      check("s1_dropped", i, bus.dropped, 0);
    end

    // Events at 0 and 2: second pulse at 12, busy falls at 24.
    for (int i = 0; i <= 26; i++) begin
      step((i == 0) || (i == 2));
      check("s2_drive", i, bus.drive_out, (i < 8) || (i >= 12 && i < 20));
      check("s2_busy", i, bus.busy, (i < 24));
      check("s2_pending", i, bus.pending, (i >= 2 && i < 12) ? 1 : 0);
    end

    // Six events in a row: queue saturates at 3, two drops, four pulses.
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i <= 50; i++) begin
      step(i <= 5);
      exp_p = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 2 : (i < 12) ? 3 :
              (i < 24) ? 2 : (i < 36) ? 1 : 0;
      check("s3_drive", i, bus.drive_out, (i < 48) && ((i % 12) < 8));
      check("s3_busy", i, bus.busy, (i < 48));
      check("s3_pending", i, bus.pending, exp_p);
      check("s3_dropped", i, bus.dropped, (i == 4) || (i == 5));
      if (bus.drive_out && !prev) rises++;
      prev = bus.drive_out;
    end
    check("s3_pulses", 0, rises, 4);
`ifdef ACT_DROP_COUNT_EN
    check("s3_drop_count", 0, bus.drop_count, 2);
`endif

    // Event exactly on the GAP exit with nothing pending.
    for (int i = 0; i <= 26; i++) begin
      step((i == 0) || (i == 12));
      check("s4_drive", i, bus.drive_out, (i < 8) || (i >= 12 && i < 20));
      check("s4_busy", i, bus.busy, (i < 24));
      check("s4_pending", i, bus.pending, 0);
    end

    // Full queue plus an event on the GAP exit: no drop, pending stays 3.
    for (int i = 0; i <= 13; i++) begin
      step((i <= 3) || (i == 12));
      check("s5_pending", i, bus.pending, (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 2 : 3);
      check("s5_dropped", i, bus.dropped, 0);
      check("s5_drive", i, bus.drive_out, (i < 8) || (i >= 12));
    end
    #3 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0);

    // Asynchronous reset in the middle of HOLD, with one event queued.
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("s6_pre_pending", 0, bus.pending, 1);
    check("s6_pre_drive", 0, bus.drive_out, 1);
    #3 reset = 1'b1;
    #1;
    check("s6_rst_drive", 0, bus.drive_out, 0);
    check("s6_rst_busy", 0, bus.busy, 0);
    check("s6_rst_pending", 0, bus.pending, 0);
    check("s6_rst_dropped", 0, bus.dropped, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0);
    step(1'b0);
    for (int i = 0; i <= 13; i++) begin
      step(i == 0);
      check("s6_drive", i, bus.drive_out, (i < 8));
      check("s6_busy", i, bus.busy, (i < 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/actuator_pulse_driver.md
# actuator_pulse_driver

Output-side counterpart of the input debouncer. It turns single-cycle internal event pulses into clean physical actuator pulses, such as gate motor strobes, buzzer chirps or LED blinks. Each pulse has a guaranteed high time and a guaranteed low gap. Events that arrive while a pulse is in progress are queued in a saturating pending counter rather than lost. The block sits between the parking controller FSM and the board output pins.

## Interface
- HOLD_CYCLES, default 8: drive_out high time in clk cycles; must be ≥1.
- GAP_CYCLES, default 4: minimum drive_out low time between pulses; must be ≥1.
- QUEUE_DEPTH, default 3: maximum queued events; must be ≥1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- event_pulse  in  1  single-cycle request, already synchronous and debounced.
- drive_out  out  1  registered actuator output.
- busy  out  1  high while state ≠ IDLE.
- pending  out  PW  queued event count, where PW = $clog2(QUEUE_DEPTH+1).
- dropped  out  1  one-cycle pulse when an event is discarded.

## Operation
- States:
  - IDLE: drive_out=0.
  - HOLD: drive_out=1.
  - GAP: drive_out=0.
- Reset values: state=IDLE; drive_out, busy, pending, dropped all 0; timer 0. Reset takes effect asynchronously, including mid-pulse.
- IDLE with event_pulse → HOLD. The timer loads HOLD_CYCLES-1. The event is not queued.
- HOLD: timer counts down; at 0 → GAP, and the timer loads GAP_CYCLES-1.
- GAP: timer counts down. At 0:
  - pending>0 → HOLD, pending decrements.
  - else event_pulse → HOLD, pending unchanged.
  - else → IDLE.
- Event in HOLD or GAP, when not consumed by the GAP-exit decision: pending increments if pending<QUEUE_DEPTH; otherwise dropped pulses.
- Event at a GAP exit with pending>0: the dequeue and enqueue net to zero, pending is unchanged, and nothing is dropped even when full.
- Timer width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)). All arithmetic is unsigned. The timer never wraps because it is always reloaded before underflow.

## Timing
- Event sampled at edge k:
  - drive_out=1 from edge k through edge k+HOLD_CYCLES-1.
  - drive_out=0 at edge k+HOLD_CYCLES.
- Earliest next drive_out rise: edge k+HOLD_CYCLES+GAP_CYCLES.
  - Back-to-back pulses therefore keep exactly GAP_CYCLES low cycles.
  - Pulses never merge.
- busy rises at edge k. It falls at edge k+HOLD_CYCLES+GAP_CYCLES when nothing is pending.
- pending and dropped update at the same edge that samples event_pulse. dropped is high for exactly one cycle per discarded event.
- All outputs are registered; there is no combinational path from event_pulse.

## Configuration
- ACT_DROP_COUNT_EN defined:
  - Adds output port drop_count, out, 8 bits.
  - Saturating count of dropped events; holds at 255.
  - Reset value 0.
- Undefined: the port and its counter are absent. dropped is still present.

## Structure
- Shared package parking_io_pkg holds:
  - the act_state_t enum (IDLE, HOLD, GAP);
  - the drop counter width constant (8).
- One sub-module, cycle_timer: loadable down-counter with a zero flag. It is reusable by other timed outputs.
- The FSM, the pending counter and the optional drop counter live in actuator_pulse_driver.

## Test plan
All scenarios use HOLD_CYCLES=8, GAP_CYCLES=4, QUEUE_DEPTH=3.
- Single event at edge 10 → drive_out high edges 10–17, low at 18; busy high 10–21, low at 22; pending stays 0.
- Events at edges 10 and 12 → pending=1 at edge 12; second pulse high edges 22–29 with pending=0 at 22; busy falls at 34.
- Event at edge 10 plus 5 events during busy → pending saturates at 3; dropped pulses twice; 4 drive pulses in total, each separated by exactly 4 low cycles; with ACT_DROP_COUNT_EN, drop_count=2.
- Event exactly at edge 22 (GAP exit, pending=0) → drive_out low edges 18–21 and high again at 22; busy never deasserts.
- Full queue with an event at the GAP-exit edge → pending stays 3 and no dropped pulse.
- reset asserted during HOLD at cycle 14 → drive_out, busy, pending, dropped drop to 0 immediately; the first event after release yields a full 8-cycle pulse.
